serial_cmp_ctrl: RTL and testbench

SERIAL_CMP_CTRL -- requirements
Module: serial_cmp_ctrl

---
 rtl/serial_cmp_ctrl.sv | 110 +++++++++++
 tb/tb_serial_cmp_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_cmp_ctrl.sv
// Bit-serial MSB-first unsigned magnitude comparator with IDLE/RUN/DONE control.
// Optional early exit on the first differing bit pair: define SERIAL_CMP_EARLY_EXIT_EN.
module serial_cmp_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             l,
  output logic             e,
  output logic             g
);

  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDX_W-1:0] r_idx;
  logic             r_decided;
  logic             r_lt;
  logic             r_gt;

  logic w_bit_lt;
  logic w_bit_gt;
  logic w_lt;
  logic w_gt;
  logic w_exit;

  assign w_bit_lt = ~r_a[WIDTH-1] &  r_b[WIDTH-1];
  assign w_bit_gt =  r_a[WIDTH-1] & ~r_b[WIDTH-1];

  // Once decided, later bit pairs never override the held result.
  assign w_lt = r_decided ? r_lt : w_bit_lt;
  assign w_gt = r_decided ? r_gt : w_bit_gt;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  assign w_exit = (r_idx == '0) | (~r_decided & (w_bit_lt | w_bit_gt));
`else
  assign w_exit = (r_idx == '0);
`endif

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_nxt = RUN;
      RUN:     if (w_exit) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_idx     <= '0;
      r_decided <= 1'b0;
      r_lt      <= 1'b0;
      r_gt      <= 1'b0;
      l         <= 1'b0;
      e         <= 1'b0;
      g         <= 1'b0;
    end else begin
      if (r_state == IDLE && start) begin
        r_a       <= a;
        r_b       <= b;
        r_idx     <= IDX_W'(WIDTH - 1);
        r_decided <= 1'b0;
        r_lt      <= 1'b0;
        r_gt      <= 1'b0;
      end else if (r_state == RUN) begin
        r_a <= {r_a[WIDTH-2:0], 1'b0};
        r_b <= {r_b[WIDTH-2:0], 1'b0};
        if (r_idx != '0) r_idx <= r_idx - 1'b1;
        if (!r_decided && (w_bit_lt || w_bit_gt)) begin
          r_decided <= 1'b1;
          r_lt      <= w_bit_lt;
          r_gt      <= w_bit_gt;
        end
        // Result outputs change only on the edge entering DONE.
        if (w_exit) begin
          l <= w_lt;
          g <= w_gt;
          e <= ~(w_lt | w_gt);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Scoreboard bench for serial_cmp_ctrl: latency, result flags, start filtering, reset abort, back-to-back.
module tb_serial_cmp_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         l;
  logic         e;
  logic         g;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [2:0] leg;
    int         due;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] prev_leg;

  always #5 clk = ~clk;

  serial_cmp_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .l     (l),
    .e     (e),
    .g     (g)
  );

  // Edges from the accepting edge (counted as 1) to the edge after which done is high.
  function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y);
    int first = -1;
    int lat;
    for (int i = 0; i < W; i++) if (x[i] != y[i]) first = i;
    lat = W + 1;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    if (first >= 0) lat = W - first + 1;
`endif
    return lat;
  endfunction

  function automatic logic [2:0] exp_leg(input logic [W-1:0] x, input logic [W-1:0] y);
    if (x < y)       return 3'b100;
    else if (x == y) return 3'b010;
    else             return 3'b001;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({busy, done, l, e, g} !== 5'b0)
      $display("FAIL reset_state: got busy/done/l/e/g=%b want 00000", {busy, done, l, e, g});
    else n_pass++;
    prev_leg = 3'b000;
    rst_n = 1'b1;
  endtask

  task automatic test_cmp(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input bit tog,
                          input string nm);
    int   n;
    bit   seen;
    exp_t x;
    @(negedge clk);
    a     = ta;
    b     = tb_v;
    start = 1'b1;
    @(posedge clk); #1;
    x.leg = exp_leg(ta, tb_v);
    x.due = exp_lat(ta, tb_v);
    sb.push_back(x);
    n_chk++;
    if (busy !== 1'b1) $display("FAIL %s_accept: got busy=%b want 1", nm, busy);
    else n_pass++;
    @(negedge clk);
    start = 1'b0;
    if (tog) begin
      a = '1;
      b = '1;
    end
    n    = 1;
    seen = 1'b0;
    while (!seen && n < 2 * W + 4) begin
      @(posedge clk); #1;
      n++;
      if (done) seen = 1'b1;
      else begin
        n_chk++;
        if ({l, e, g} !== prev_leg)
          $display("FAIL %s_hold_run: got leg=%b want %b at edge %0d", nm, {l, e, g}, prev_leg, n);
        else n_pass++;
      end
    end
    x = sb.pop_front();
    if (!seen) begin
      n_chk++;
      $display("FAIL %s_timeout: got no done within %0d edges want done at %0d", nm, n, x.due);
    end else begin
      n_chk++;
      if (n !== x.due) $display("FAIL %s_latency: got %0d want %0d", nm, n, x.due);
      else n_pass++;
      n_chk++;
      if ({l, e, g} !== x.leg) $display("FAIL %s_result: got leg=%b want %b", nm, {l, e, g}, x.leg);
      else n_pass++;
      prev_leg = x.leg;
    end
    @(posedge clk); #1;
    n_chk++;
    if ({done, busy} !== 2'b00) $display("FAIL %s_pulse_end: got done/busy=%b want 00", nm, {done, busy});
    else n_pass++;
  endtask

  task automatic test_ignore_start();
    int   dn;
    int   cnt;
    exp_t x;
    @(negedge clk);
    a     = 8'h33;
    b     = 8'h33;
    start = 1'b1;
    @(posedge clk); #1;
    x.leg = exp_leg(8'h33, 8'h33);
    x.due = exp_lat(8'h33, 8'h33);
    sb.push_back(x);
    dn  = 0;
    cnt = 0;
    for (int n = 2; n <= 2 * W + 6; n++) begin
      @(negedge clk);
      start = (n == 4) || (dn != 0 && n == dn + 1);
      @(posedge clk); #1;
      if (done) begin
        cnt++;
        if (dn == 0) dn = n;
      end
    end
    start = 1'b0;
    x = sb.pop_front();
    n_chk++;
    if (cnt !== 1) $display("FAIL ignore_done_count: got %0d want 1", cnt);
    else n_pass++;
    n_chk++;
    if (dn !== x.due) $display("FAIL ignore_latency: got %0d want %0d", dn, x.due);
    else n_pass++;
    n_chk++;
    if ({l, e, g} !== x.leg) $display("FAIL ignore_result: got leg=%b want %b", {l, e, g}, x.leg);
    else n_pass++;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL ignore_idle: got busy=%b want 0", busy);
    else n_pass++;
    prev_leg = x.leg;
  endtask

  task automatic test_reset_midrun();
    int   cnt;
    exp_t x;
    @(negedge clk);
    a     = 8'h10;
    b     = 8'h20;
    start = 1'b1;
    @(posedge clk); #1;
    x.leg = exp_leg(8'h10, 8'h20);
    x.due = exp_lat(8'h10, 8'h20);
    sb.push_back(x);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    n_chk++;
    if ({busy, done, l, e, g} !== 5'b0)
      $display("FAIL midrun_reset_async: got busy/done/l/e/g=%b want 00000", {busy, done, l, e, g});
    else n_pass++;
    prev_leg = 3'b000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int n = 0; n < 2 * W; n++) begin
      @(posedge clk); #1;
      if (done || busy || ({l, e, g} != 3'b000)) cnt++;
    end
    n_chk++;
    if (cnt !== 0) $display("FAIL midrun_no_done: got %0d active cycles want 0", cnt);
    else n_pass++;
    test_cmp(8'h10, 8'h10, 1'b0, "post_reset_eq");
  endtask

  task automatic test_back_to_back();
    int   next_acc;
    int   pushed;
    int   dcnt;
    exp_t x;
    @(negedge clk);
    a        = 8'h03;
    b        = 8'h04;
    start    = 1'b1;
    next_acc = 1;
    pushed   = 0;
    dcnt     = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (c == next_acc && c <= 40) begin
        x.leg = exp_leg(8'h03, 8'h04);
        x.due = c + exp_lat(8'h03, 8'h04) - 1;
        sb.push_back(x);
        pushed++;
        next_acc = c + exp_lat(8'h03, 8'h04) + 1;
      end
      if (done) begin
        dcnt++;
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL b2b_unexpected_done: got done at edge %0d want none", c);
        end else begin
          x = sb.pop_front();
          n_chk++;
          if (c !== x.due) $display("FAIL b2b_done_edge: got %0d want %0d", c, x.due);
          else n_pass++;
          n_chk++;
          if ({l, e, g} !== x.leg) $display("FAIL b2b_result: got leg=%b want %b", {l, e, g}, x.leg);
          else n_pass++;
        end
      end
      if (c == 40) begin
        @(negedge clk);
        start = 1'b0;
      end
    end
    n_chk++;
    if (dcnt !== pushed) $display("FAIL b2b_done_count: got %0d want %0d", dcnt, pushed);
    else n_pass++;
    n_chk++;
    if (sb.size() !== 0) $display("FAIL b2b_drain: got %0d pending want 0", sb.size());
    else n_pass++;
    prev_leg = 3'b100;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cmp(8'h5A, 8'h5A, 1'b0, "eq_5a");
    test_cmp(8'h80, 8'h7F, 1'b0, "gt_msb");
    test_cmp(8'h01, 8'h02, 1'b1, "lt_toggle");
    test_cmp(8'hFE, 8'hFF, 1'b0, "lt_lsb");
    test_cmp(8'hFF, 8'h00, 1'b1, "gt_max");
    test_cmp(8'h00, 8'h00, 1'b0, "eq_zero");
    test_ignore_start();
    test_reset_midrun();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
